seven_segment_bcd_reader: RTL and testbench
===========================================

// Module: seven_segment_bcd_reader
// PURPOSE
//   Reverse path of the two-digit BCD seven-segment display driver: takes two
//   raw segment buses (digit 0 = ones, digit 1 = tens) and recovers BCD
//   digits, blank/error flags and the binary value 0..99.
//   Inputs are glitch-filtered: a pattern pair must be stable for
//   STABLE_CYCLES clocks before it is committed.
//   Used for display loopback checking and for reading external 7-seg sources.
// PARAMETERS
//   STABLE_CYCLES  4  consecutive equal samples required to commit (range 1..15)
//   ACTIVE_LOW     1  1: segment lit = 0 (native display polarity); 0: lit = 1
// PORTS
//   clk        in   1  system clock, all logic on rising edge
//   reset      in   1  synchronous, active-high reset
//   seg0       in   7  ones-digit segments, bit6=a ... bit0=g
//   seg1       in   7  tens-digit segments, same bit order
//   bcd0       out  4  committed ones digit, 4'hF when blank/error
//   bcd1       out  4  committed tens digit, 4'hF when blank/error
//   blank0/1   out  1  committed digit is all segments off
//   err0/1     out  1  committed digit is not a legal 0..9 or blank pattern
//   value_bin  out  7  bcd1*10+bcd0, binary
//   value_ok   out  1  value_bin is meaningful
//   valid      out  1  one-cycle pulse: new commit this cycle
// BEHAVIOUR
//   - Normalise: n = ACTIVE_LOW ? seg : ~seg (so lit = 0 internally).
//   - Decode table on n (lit=0): 0=0000001 1=1001111 2=0010010 3=0000110
//     4=1001100 5=0100100 6=0100000 7=0001111 8=0000000 9=0000100;
//     1111111 -> blank=1, bcd=F, err=0; any other code -> err=1, bcd=F, blank=0.
//   - Sample reg s_q <= {seg1,seg0} every clock; reset value = raw blank
//     (7'h7F each if ACTIVE_LOW=1, 7'h00 if 0).
//   - FSM states SETTLE, LOCKED; counter cnt (4 bit).
//     * {seg1,seg0} != s_q: cnt<=0, state<=SETTLE (from either state).
//     * Equal and SETTLE: if cnt==STABLE_CYCLES-1 -> commit decoded s_q,
//       valid<=1, state<=LOCKED, cnt<=0; else cnt<=cnt+1.
//     * Equal and LOCKED: hold all outputs, valid<=0.
//   - Latency: pattern changes before edge E0 and is held -> outputs and valid
//     update at edge E_STABLE_CYCLES (STABLE_CYCLES=4: 5th edge from E0).
//   - valid pulses on every commit, including re-commit of an unchanged value
//     after a rejected glitch; never high two cycles in a row.
//   - value_bin = (bcd1<<3)+(bcd1<<1)+bcd0 when both digits legal;
//     blank tens + legal ones -> value_bin = bcd0 (leading blank = 0);
//     otherwise value_bin = 7'h7F, value_ok = 0. Max legal value 99.
//   - Reset (sync, any cycle, dominates): state SETTLE, cnt 0, bcd0/1=F,
//     blank0/1=1, err0/1=0, value_bin=0, value_ok=0, valid=0.
//   - Reset mid-settle discards partial count; commit needs a full
//     STABLE_CYCLES window after reset deasserts.
// TESTING
//   1 Reset, drive seg1=0010010 seg0=0000110 (ACTIVE_LOW=1) steady -> after 5
//     edges bcd1=2 bcd0=3 value_bin=23 value_ok=1, valid high exactly 1 cycle.
//   2 Locked at 23, seg0 glitches to 0000000 for 2 cycles then back ->
//     outputs never show 8, stay 23, one valid pulse on re-commit.
//   3 seg1=1111111 seg0=0100100 -> blank1=1 bcd1=F bcd0=5 value_bin=5 value_ok=1.
//   4 seg0=1010101 (illegal) -> err0=1 bcd0=F value_bin=7F value_ok=0.
//   5 Sweep 00..99 with 6-cycle holds -> each value committed once, value_bin
//     matches; ACTIVE_LOW=0 build with inverted stimulus gives identical results.
//   6 Assert reset 2 cycles into a settle window -> reset values next edge,
//     no valid; release, hold pattern -> commit exactly 5 edges later.

Source files
------------

// File: rtl/seven_segment_bcd_reader.sv
// Recovers two BCD digits, blank/error flags and a 0..99 binary value from
// raw seven-segment buses, committing a pattern pair only after it has been stable.
module seven_segment_bcd_reader #(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter bit          ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg0,
   input  logic [6:0] seg1,
   output logic [3:0] bcd0,
   output logic [3:0] bcd1,
   output logic       blank0,
   output logic       blank1,
   output logic       err0,
   output logic       err1,
   output logic [6:0] value_bin,
   output logic       value_ok,
   output logic       valid
);

   localparam logic [6:0] RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0] CNT_LAST  = 4'(STABLE_CYCLES - 1);

   typedef enum logic {SETTLE, LOCKED} state_t;

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic [13:0] sample_reg;
   logic [13:0] sample_now;

   logic [7:0]  bcd_reg, bcd_next;
   logic [1:0]  blank_reg, blank_next;
   logic [1:0]  err_reg, err_next;
   logic [6:0]  value_reg, value_next;
   logic        ok_reg, ok_next;
   logic        valid_reg, valid_next;

   // Decoded view of the previous sample; this is what gets committed.
   logic [7:0]  dig_bcd;
   logic [1:0]  dig_blank;
   logic [1:0]  dig_err;
   logic [6:0]  calc_value;
   logic        calc_ok;

   assign sample_now = {seg1, seg0};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dec
         logic [6:0] norm;
         logic [3:0] bcd_g;
         logic       blank_g;
         logic       err_g;

         // Internally a lit segment is always 0.
         assign norm = ACTIVE_LOW ? sample_reg[gi*7 +: 7] : ~sample_reg[gi*7 +: 7];

         always_comb begin
            bcd_g   = 4'hF;
            blank_g = 1'b0;
            err_g   = 1'b0;
            case (norm)
               7'b0000001: bcd_g = 4'd0;
               7'b1001111: bcd_g = 4'd1;
               7'b0010010: bcd_g = 4'd2;
               7'b0000110: bcd_g = 4'd3;
               7'b1001100: bcd_g = 4'd4;
               7'b0100100: bcd_g = 4'd5;
               7'b0100000: bcd_g = 4'd6;
               7'b0001111: bcd_g = 4'd7;
               7'b0000000: bcd_g = 4'd8;
               7'b0000100: bcd_g = 4'd9;
               7'b1111111: blank_g = 1'b1;
               default:    err_g   = 1'b1;
            endcase
         end

         assign dig_bcd[gi*4 +: 4] = bcd_g;
         assign dig_blank[gi]      = blank_g;
         assign dig_err[gi]        = err_g;
      end
   endgenerate

   // A blank tens digit in front of a legal ones digit reads as a leading zero.
   always_comb begin
      calc_value = 7'h7F;
      calc_ok    = 1'b0;
      if (!dig_blank[0] && !dig_err[0]) begin
         if (!dig_blank[1] && !dig_err[1]) begin
            calc_value = {dig_bcd[7:4], 3'b000} + {2'b00, dig_bcd[7:4], 1'b0}
                       + {3'b000, dig_bcd[3:0]};
            calc_ok    = 1'b1;
         end else if (dig_blank[1]) begin
            calc_value = {3'b000, dig_bcd[3:0]};
            calc_ok    = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bcd_next   = bcd_reg;
      blank_next = blank_reg;
      err_next   = err_reg;
      value_next = value_reg;
      ok_next    = ok_reg;
      valid_next = 1'b0;
      if (sample_now != sample_reg) begin
         state_next = SETTLE;
         cnt_next   = 4'd0;
      end else if (state_reg == SETTLE) begin
         if (cnt_reg == CNT_LAST) begin
            state_next = LOCKED;
            cnt_next   = 4'd0;
            bcd_next   = dig_bcd;
            blank_next = dig_blank;
            err_next   = dig_err;
            value_next = calc_value;
            ok_next    = calc_ok;
            valid_next = 1'b1;
         end else begin
            cnt_next = cnt_reg + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sample_reg <= {RAW_BLANK, RAW_BLANK};
         state_reg  <= SETTLE;
         cnt_reg    <= 4'd0;
         bcd_reg    <= 8'hFF;
         blank_reg  <= 2'b11;
         err_reg    <= 2'b00;
         value_reg  <= 7'd0;
         ok_reg     <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         sample_reg <= sample_now;
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         bcd_reg    <= bcd_next;
         blank_reg  <= blank_next;
         err_reg    <= err_next;
         value_reg  <= value_next;
         ok_reg     <= ok_next;
         valid_reg  <= valid_next;
      end
   end

   assign bcd0      = bcd_reg[3:0];
   assign bcd1      = bcd_reg[7:4];
   assign blank0    = blank_reg[0];
   assign blank1    = blank_reg[1];
   assign err0      = err_reg[0];
   assign err1      = err_reg[1];
   assign value_bin = value_reg;
   assign value_ok  = ok_reg;
   assign valid     = valid_reg;

endmodule

// File: tb/tb_seven_segment_bcd_reader.sv
// Scoreboard bench: an active-low and an active-high instance see the same
// (inverted) stimulus and must both match the expected commits and hold values.
module tb_seven_segment_bcd_reader;

   localparam int S = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg0_l, seg1_l, seg0_h, seg1_h;

   logic [3:0] bcd0_l, bcd1_l, bcd0_h, bcd1_h;
   logic       blank0_l, blank1_l, err0_l, err1_l, value_ok_l, valid_l;
   logic       blank0_h, blank1_h, err0_h, err1_h, value_ok_h, valid_h;
   logic [6:0] value_bin_l, value_bin_h;

   always #5 clk = ~clk;

   assign seg0_h = ~seg0_l;
   assign seg1_h = ~seg1_l;

   seven_segment_bcd_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk(clk), .reset(reset), .seg0(seg0_l), .seg1(seg1_l),
      .bcd0(bcd0_l), .bcd1(bcd1_l), .blank0(blank0_l), .blank1(blank1_l),
      .err0(err0_l), .err1(err1_l), .value_bin(value_bin_l),
      .value_ok(value_ok_l), .valid(valid_l)
   );

   seven_segment_bcd_reader #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk(clk), .reset(reset), .seg0(seg0_h), .seg1(seg1_h),
      .bcd0(bcd0_h), .bcd1(bcd1_h), .blank0(blank0_h), .blank1(blank1_h),
      .err0(err0_h), .err1(err1_h), .value_bin(value_bin_h),
      .value_ok(value_ok_h), .valid(valid_h)
   );

   logic [19:0] obs_l, obs_h;
   assign obs_l = {bcd1_l, bcd0_l, blank1_l, blank0_l, err1_l, err0_l, value_bin_l, value_ok_l};
   assign obs_h = {bcd1_h, bcd0_h, blank1_h, blank0_h, err1_h, err0_h, value_bin_h, value_ok_h};

   localparam logic [19:0] RESET_VEC = {4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0};

   // Index 0..9 digits (active-low), 10 = blank, 11 = illegal pattern.
   logic [6:0] seg_tab [12] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b1111111, 7'b1010101};

   typedef struct {
      int          cyc;
      logic [19:0] vec;
   } exp_t;

   exp_t        sb[$];
   logic [19:0] last = RESET_VEC;
   int          cyc = 0;
   bit          rst_seen = 1'b0;
   bit          mon_en = 1'b0;
   bit          exp_v;
   int          total = 0;
   int          bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [19:0] exp_vec(input int t, input int o);
      logic [3:0] b1, b0;
      logic [6:0] v;
      logic       ok;
      b1 = (t < 10) ? 4'(t) : 4'hF;
      b0 = (o < 10) ? 4'(o) : 4'hF;
      if (t < 10 && o < 10) begin
         v = 7'(t * 10 + o); ok = 1'b1;
      end else if (t == 10 && o < 10) begin
         v = 7'(o); ok = 1'b1;
      end else begin
         v = 7'h7F; ok = 1'b0;
      end
      return {b1, b0, t == 10, o == 10, t == 11, o == 11, v, ok};
   endfunction

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
      mon_en   <= 1'b1;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         if (rst_seen) begin
            sb.delete();
            last = RESET_VEC;
         end
         exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
         check("valid_lo", 32'(valid_l), 32'(exp_v));
         check("valid_hi", 32'(valid_h), 32'(exp_v));
         if (exp_v) begin
            last = sb[0].vec;
            void'(sb.pop_front());
         end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            void'(sb.pop_front());
         end
         check("out_lo", 32'(obs_l), 32'(last));
         check("out_hi", 32'(obs_h), 32'(last));
         if (valid_l)
            $display("commit cyc=%0d bcd1=%0h bcd0=%0h value=%0d ok=%0b",
                     cyc, bcd1_l, bcd0_l, value_bin_l, value_ok_l);
      end
   end

   task automatic drive(input int t, input int o, input int hold, input bit push);
      @(posedge clk);
      #2;
      seg1_l = seg_tab[t];
      seg0_l = seg_tab[o];
      if (push) sb.push_back('{cyc + 1 + S, exp_vec(t, o)});
      repeat (hold - 1) @(posedge clk);
   endtask

   // Called just after the last reset-sampling edge; the pattern must already be on the bus.
   task automatic release_rst(input int t, input int o);
      int k;
      #2;
      reset = 1'b0;
      k = cyc;
      @(negedge clk);
      #1;
      sb.push_back('{k + 1 + S, exp_vec(t, o)});
   endtask

   initial begin
      seg1_l = seg_tab[2];
      seg0_l = seg_tab[3];
      repeat (3) @(posedge clk);
      release_rst(2, 3);
      repeat (7) @(posedge clk);

      // Two-cycle glitch to 8, then back: value must stay 23 and re-commit once.
      drive(2, 8, 2, 1'b0);
      drive(2, 3, 8, 1'b1);

      drive(10, 5, 8, 1'b1);
      drive(7, 11, 8, 1'b1);

      for (int t = 0; t < 10; t++)
         for (int o = 0; o < 10; o++)
            drive(t, o, 6, 1'b1);

      // Reset two cycles into a settle window, then a full window after release.
      drive(4, 5, 2, 1'b0);
      #2 reset = 1'b1;
      @(posedge clk);
      release_rst(4, 5);
      repeat (8) @(posedge clk);

      @(negedge clk);
      check("drain", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
